// File: rtl/tug_game_ctrl_pkg.sv
// rtl/tug_game_ctrl_pkg.sv - shared types and constants for the tug-of-war controller
package tug_pkg;
  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    WIN_HOLD = 2'd1,
    DONE     = 2'd2
  } tug_state_e;

  localparam int LIGHT_N   = 9;
  localparam int CENTER    = 4;
  localparam int WIN_SCORE = 7;
  localparam int POS_W     = 4;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b10;
  localparam logic [1:0] WIN_RIGHT = 2'b01;
endpackage

// File: rtl/tug_game_ctrl_if.sv
// rtl/tug_game_ctrl_if.sv - player keys, computer speed and display/score signals
interface tug_game_ctrl_if;
  logic       L;
  logic       R;
  logic [9:0] Speed;
  logic [8:0] lights;
  logic [1:0] winner;
  logic [2:0] leftScore;
  logic [2:0] rightScore;

  modport master (output L, R, Speed, input lights, winner, leftScore, rightScore);
  modport slave  (input L, R, Speed, output lights, winner, leftScore, rightScore);
endinterface

// File: rtl/tug_game_ctrl_lfsr.sv
// rtl/tug_game_ctrl_lfsr.sv - 10-bit Fibonacci LFSR (taps 10,7) driving the computer player
module tug_lfsr (
  input  logic       Clock,
  input  logic       Reset,
  output logic [9:0] value
);
  logic [9:0] r_lfsr;
  logic       w_fb;

  assign w_fb  = r_lfsr[9] ^ r_lfsr[6];
  assign value = r_lfsr;

  always_ff @(posedge Clock) begin
    if (Reset) r_lfsr <= 10'h001;
    else       r_lfsr <= {r_lfsr[8:0], w_fb};
  end
endmodule

// File: rtl/tug_game_ctrl.sv
// rtl/tug_game_ctrl.sv - tug-of-war game FSM with scoring and win hold
// Build option: CPU_PLAYER_EN replaces the right key with an LFSR-driven computer player.
module tug_game_ctrl
  import tug_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  tug_game_ctrl_if.slave       gif
);
  localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  tug_state_e       r_state, w_state_nx;
  logic [POS_W-1:0] r_pos, w_pos_nx;
  logic [1:0]       r_winner, w_winner_nx;
  logic [2:0]       r_left_score, w_left_score_nx;
  logic [2:0]       r_right_score, w_right_score_nx;
  logic [HW-1:0]    r_hold_cnt, w_hold_cnt_nx;
  logic             r_l_prev;
  logic             w_l_press, w_r_press;

  assign w_l_press = gif.L && !r_l_prev;

`ifdef CPU_PLAYER_EN
  logic [9:0] w_lfsr;

  tug_lfsr u_lfsr (
    .Clock (Clock),
    .Reset (Reset),
    .value (w_lfsr)
  );

  // The computer presses as a raw pulse; no edge detection on its output.
  assign w_r_press = (w_lfsr < gif.Speed);
`else
  logic r_r_prev;

  always_ff @(posedge Clock) begin
    if (Reset) r_r_prev <= 1'b0;
    else       r_r_prev <= gif.R;
  end

  assign w_r_press = gif.R && !r_r_prev;
`endif

  always_comb begin
    w_state_nx       = r_state;
    w_pos_nx         = r_pos;
    w_winner_nx      = r_winner;
    w_left_score_nx  = r_left_score;
    w_right_score_nx = r_right_score;
    w_hold_cnt_nx    = r_hold_cnt;
    case (r_state)
      PLAY: begin
        if (w_l_press && !w_r_press) begin
          if (r_pos == POS_W'(LIGHT_N - 1)) begin
            w_winner_nx     = WIN_LEFT;
            w_left_score_nx = r_left_score + 3'd1;
            w_hold_cnt_nx   = '0;
            w_state_nx      = (r_left_score == 3'(WIN_SCORE - 1)) ? DONE : WIN_HOLD;
          end else begin
            w_pos_nx = r_pos + POS_W'(1);
          end
        end else if (w_r_press && !w_l_press) begin
          if (r_pos == '0) begin
            w_winner_nx      = WIN_RIGHT;
            w_right_score_nx = r_right_score + 3'd1;
            w_hold_cnt_nx    = '0;
            w_state_nx       = (r_right_score == 3'(WIN_SCORE - 1)) ? DONE : WIN_HOLD;
          end else begin
            w_pos_nx = r_pos - POS_W'(1);
          end
        end
      end
      WIN_HOLD: begin
        if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          w_state_nx    = PLAY;
          w_pos_nx      = POS_W'(CENTER);
          w_winner_nx   = WIN_NONE;
          w_hold_cnt_nx = '0;
        end else begin
          w_hold_cnt_nx = r_hold_cnt + HW'(1);
        end
      end
      DONE: ;
      default: w_state_nx = PLAY;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state       <= PLAY;
      r_pos         <= POS_W'(CENTER);
      r_winner      <= WIN_NONE;
      r_left_score  <= '0;
      r_right_score <= '0;
      r_hold_cnt    <= '0;
      r_l_prev      <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_pos         <= w_pos_nx;
      r_winner      <= w_winner_nx;
      r_left_score  <= w_left_score_nx;
      r_right_score <= w_right_score_nx;
      r_hold_cnt    <= w_hold_cnt_nx;
      r_l_prev      <= gif.L;
    end
  end

  assign gif.lights     = (r_state == PLAY) ? (LIGHT_N'(1) << r_pos) : '0;
  assign gif.winner     = r_winner;
  assign gif.leftScore  = r_left_score;
  assign gif.rightScore = r_right_score;
endmodule

// File: tb/tb_tug_game_ctrl.sv
// tb/tb_tug_game_ctrl.sv - directed self-checking bench for tug_game_ctrl
module tb_tug_game_ctrl;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  tug_game_ctrl_if gif ();

  tug_game_ctrl #(.HOLD_CYCLES(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .gif   (gif.slave)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic press_l();
    gif.L = 1'b1; tick();
    gif.L = 1'b0; tick();
  endtask

  task automatic press_r();
    gif.R = 1'b1; tick();
    gif.R = 1'b0; tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1; tick();
    Reset = 1'b0;
  endtask

  // Five presses from center win; the fifth press's idle tick is hold cycle 2, then 3 more end the hold.
  task automatic win_left_round();
    for (int i = 0; i < 5; i++) press_l();
    repeat (3) tick();
  endtask

  initial begin
    gif.L = 1'b0; gif.R = 1'b0; gif.Speed = 10'd0;
    #1;
    do_reset();
    check("reset_lights", gif.lights, 9'b000010000);
    check("reset_winner", gif.winner, 2'b00);
    check("reset_lscore", gif.leftScore, 0);
    check("reset_rscore", gif.rightScore, 0);

    gif.L = 1'b1; tick();
    check("hold_l_first", gif.lights, 9'b000100000);
    repeat (4) tick();
    check("hold_l_after", gif.lights, 9'b000100000);
    gif.L = 1'b0; tick();

    gif.L = 1'b1; Reset = 1'b1; tick();
    Reset = 1'b0;
    check("reset_prio", gif.lights, 9'b000010000);
    gif.L = 1'b0; tick();

`ifndef CPU_PLAYER_EN
    gif.L = 1'b1; gif.R = 1'b1; tick();
    check("cancel_lights", gif.lights, 9'b000010000);
    check("cancel_scores", {gif.leftScore, gif.rightScore}, 0);
    gif.L = 1'b0; gif.R = 1'b0; tick();

    press_r();
    check("right_move", gif.lights, 9'b000001000);
    press_l();
    check("back_center", gif.lights, 9'b000010000);
`endif

    for (int i = 0; i < 4; i++) press_l();
    check("four_presses", gif.lights, 9'b100000000);
    gif.L = 1'b1; tick();
    check("win_winner", gif.winner, 2'b10);
    check("win_lscore", gif.leftScore, 1);
    check("hold_c1", gif.lights, 0);
    gif.L = 1'b0; tick();
    check("hold_c2", gif.lights, 0);
    gif.L = 1'b1; tick();
    check("hold_c3", gif.lights, 0);
    gif.L = 1'b0; tick();
    check("hold_c4", gif.lights, 0);
    check("hold_c4_winner", gif.winner, 2'b10);
    tick();
    check("after_hold_lights", gif.lights, 9'b000010000);
    check("after_hold_winner", gif.winner, 2'b00);
    check("after_hold_lscore", gif.leftScore, 1);

    for (int r = 0; r < 5; r++) win_left_round();
    check("six_wins", gif.leftScore, 6);
    check("six_wins_lights", gif.lights, 9'b000010000);
    for (int i = 0; i < 5; i++) press_l();
    check("done_lscore", gif.leftScore, 7);
    check("done_winner", gif.winner, 2'b10);
    check("done_lights", gif.lights, 0);
    repeat (6) tick();
    press_l();
    press_r();
    check("done_frozen_l", gif.leftScore, 7);
    check("done_frozen_r", gif.rightScore, 0);
    check("done_frozen_lights", gif.lights, 0);
    check("done_frozen_winner", gif.winner, 2'b10);
    do_reset();
    check("rst_done_lights", gif.lights, 9'b000010000);
    check("rst_done_winner", gif.winner, 2'b00);
    check("rst_done_lscore", gif.leftScore, 0);

`ifndef CPU_PLAYER_EN
    for (int i = 0; i < 5; i++) press_r();
    check("rwin_winner", gif.winner, 2'b01);
    check("rwin_rscore", gif.rightScore, 1);
    check("rwin_lights", gif.lights, 0);
    do_reset();
    check("rst_midhold_lights", gif.lights, 9'b000010000);
    check("rst_midhold_winner", gif.winner, 2'b00);
    check("rst_midhold_rscore", gif.rightScore, 0);
`else
    begin
      int moved;
      gif.Speed = 10'd0;
      for (int i = 0; i < 100; i++) begin
        gif.R = ~gif.R; tick();
      end
      check("cpu_speed0", gif.lights, 9'b000010000);
      gif.Speed = 10'h3FF;
      moved = 0;
      for (int i = 0; i < 2; i++) begin
        gif.R = ~gif.R; tick();
        if (gif.lights != 9'b000010000) moved = 1;
      end
      check("cpu_speedmax", moved, 1);
      gif.Speed = 10'd0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tug_game_ctrl.md
TUG_GAME_CTRL -- requirements
Module: tug_game_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: number of cycles the win display is held before the next round starts.
REQ-002 SHALL have port Clock, input, 1: system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port L, input, 1: left player key level, active-high.
REQ-005 SHALL have port R, input, 1: right player key level, active-high.
REQ-006 SHALL have port Speed, input, 10: computer-player press threshold; ignored unless CPU_PLAYER_EN is defined.
REQ-007 SHALL have port lights, output, 9: one-hot rope position, with bit 8 leftmost.
REQ-008 SHALL have port winner, output, 2: 00 none, 10 left, 01 right; the code 11 is never driven.
REQ-009 SHALL have ports leftScore and rightScore, outputs, 3 bits each: rounds won per side.

Function
REQ-010 SHALL detect presses as rising edges: a press is L=1 while the registered previous L=0 (same for R); a held key yields exactly one press.
REQ-011 SHALL update position at the same Clock edge that first samples the key high, giving 1-cycle latency from key assert to new lights.
REQ-012 SHALL use FSM states PLAY, WIN_HOLD and DONE.
REQ-013 In PLAY, position SHALL be held in 0..8 and lights SHALL equal 1<<pos.
REQ-014 In PLAY, a left-only press SHALL increment pos and a right-only press SHALL decrement it.
REQ-015 SHALL treat left and right presses in the same cycle as cancelled: no move and no score change.
REQ-016 A left press at pos=8 SHALL give a left win: winner=10, leftScore+1, go to WIN_HOLD. A right press at pos=0 SHALL be the mirror case: winner=01, rightScore+1, go to WIN_HOLD.
REQ-017 In WIN_HOLD, lights SHALL be 0, winner SHALL be held and presses SHALL be ignored.
REQ-018 WIN_HOLD SHALL last HOLD_CYCLES cycles, then set pos=4, winner=00 and return to PLAY.
REQ-019 If the winning side's score reaches 7 at a win, the FSM SHALL go to DONE instead of WIN_HOLD.
REQ-020 In DONE, lights SHALL be 0, winner and scores SHALL be frozen, and all presses SHALL be ignored until Reset.
REQ-021 Scores SHALL never wrap; 7 is terminal via DONE.
REQ-022 The hold counter SHALL be wide enough for HOLD_CYCLES and SHALL be cleared on entry to WIN_HOLD.

Reset
REQ-023 On Reset=1 at a Clock edge, from any state including mid-hold, the block SHALL go to PLAY with pos=4, lights=9'b000010000, winner=00, both scores 0, edge registers 0, hold counter 0 and LFSR=10'h001.
REQ-024 Reset SHALL take priority over every press in the same cycle.

Configuration
REQ-025 The macro CPU_PLAYER_EN SHALL select the computer player.
REQ-026 With CPU_PLAYER_EN defined:
- A 10-bit Fibonacci LFSR (taps 10,7) SHALL advance every cycle.
- The right press SHALL be (LFSR < Speed), used directly as a pulse without edge detection.
- Port R SHALL be ignored.
REQ-027 Without CPU_PLAYER_EN, the LFSR logic SHALL be absent, R SHALL be edge-detected per REQ-010, and Speed SHALL be unused.

Structure
REQ-028 Package tug_pkg SHALL hold:
- the state enum;
- LIGHT_N=9, CENTER=4, WIN_SCORE=7;
- the winner encodings WIN_NONE, WIN_LEFT and WIN_RIGHT.
REQ-029 The LFSR SHALL be sub-module tug_lfsr (Clock, Reset, value[9:0]), instantiated only under CPU_PLAYER_EN.

Verification
REQ-030 Reset for 1 cycle -> lights=000010000, winner=00, leftScore=0, rightScore=0.
REQ-031 L held high for 5 cycles from center -> lights=000100000 after the first edge, unchanged afterwards.
REQ-032 L and R rising in the same cycle at center -> lights stay 000010000 and scores stay 0.
REQ-033 Five separate left presses from center:
- lights=100000000 after the fourth press;
- after the fifth press, winner=10 and leftScore=1;
- lights=0 for 4 cycles (default HOLD_CYCLES);
- then lights=000010000 and winner=00.
REQ-034 Left wins 7 rounds -> DONE with leftScore=7, winner=10 and lights=0; further L/R presses change nothing; Reset restores REQ-030 values.
REQ-035 With CPU_PLAYER_EN defined:
- Speed=0 for 100 cycles -> no right moves;
- Speed=10'h3FF -> a right move within 2 cycles;
- R toggling has no effect in either case.
